// File: rtl/caplog_pkg.sv
// Shared types and constants for the timer capture log.
package caplog_pkg;

  localparam int unsigned CAP_W   = 32;
  localparam int unsigned ENTRY_W = 33;

  localparam logic [CAP_W-1:0] MIN_RESET = 32'hFFFF_FFFF;
  localparam logic [15:0]      DROP_MAX  = 16'hFFFF;

  typedef struct packed {
    logic             ovf;
    logic [CAP_W-1:0] count;
  } caplog_entry_t;

endpackage

// File: rtl/caplog_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head is a combinational array read.
module caplog_fifo
  import caplog_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  caplog_entry_t            wr_data,
  input  logic                     pop,
  output caplog_entry_t            rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  caplog_entry_t   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop_ok;
  logic            push_ok;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/timer_capture_log.sv
// Logs each capture_complete rising edge into a FWFT FIFO with drop/sample counters.
// Optional min/max/sum statistics are built when CAPLOG_STATS_EN is defined.
module timer_capture_log
  import caplog_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SUM_W = 48
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     AXI_RESET,
  input  logic                     capture_complete,
  input  logic [31:0]              cap_timer_out,
  input  logic                     overflow_flag,
  input  logic                     clear,
  input  logic                     rd_pop,
  output logic [32:0]              rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     fifo_full,
  output logic [15:0]              drop_count,
  output logic [31:0]              sample_count,
  output logic [31:0]              min_count,
  output logic [31:0]              max_count,
  output logic [SUM_W-1:0]         sum_count
);

  logic          cap_d;
  logic          evt;
  logic          fifo_empty;
  caplog_entry_t head;
  caplog_entry_t sample;

  // cap_d resets high so a level already asserted at reset release is ignored.
  always_ff @(posedge S_AXI_ACLK) begin
    if (AXI_RESET) cap_d <= 1'b1;
    else           cap_d <= capture_complete;
  end

  assign evt    = capture_complete & ~cap_d & ~clear;
  assign sample = '{ovf: overflow_flag, count: cap_timer_out};

  caplog_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (S_AXI_ACLK),
    .rst     (AXI_RESET),
    .flush   (clear),
    .push    (evt),
    .wr_data (sample),
    .pop     (rd_pop & ~clear),
    .rd_data (head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_data  = head;
  assign rd_valid = ~fifo_empty;

  always_ff @(posedge S_AXI_ACLK) begin
    if (AXI_RESET || clear) begin
      drop_count   <= '0;
      sample_count <= '0;
    end else if (evt) begin
      if (sample_count != '1) sample_count <= sample_count + 32'd1;
      if (fifo_full && !rd_pop && drop_count != DROP_MAX)
        drop_count <= drop_count + 16'd1;
    end
  end

`ifdef CAPLOG_STATS_EN
  logic [SUM_W:0] sum_nxt;

  assign sum_nxt = {1'b0, sum_count} + (SUM_W+1)'(cap_timer_out);

  always_ff @(posedge S_AXI_ACLK) begin
    if (AXI_RESET || clear) begin
      min_count <= MIN_RESET;
      max_count <= '0;
      sum_count <= '0;
    end else if (evt) begin
      if (cap_timer_out < min_count) min_count <= cap_timer_out;
      if (cap_timer_out > max_count) max_count <= cap_timer_out;
      sum_count <= sum_nxt[SUM_W] ? '1 : sum_nxt[SUM_W-1:0];
    end
  end
`else
  assign min_count = '0;
  assign max_count = '0;
  assign sum_count = '0;
`endif

endmodule
